// File: rtl/doorlock_ctrl.sv
// Keypad-side doorlock controller: collects a 4-digit BCD code, checks it against
// the stored password, and sequences the open / error / lockout timed states.
module doorlock_ctrl #(
   parameter logic [15:0] DEFAULT_PW = 16'h1234,
   parameter int unsigned OPEN_CYC   = 1000,
   parameter int unsigned ERR_CYC    = 200,
   parameter int unsigned LOCK_CYC   = 5000,
   parameter int unsigned MAX_FAIL   = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic        open,
   output logic        err,
   output logic        locked,
   output logic [15:0] entry,
   output logic [2:0]  entry_cnt,
   output logic        pw_saved
);

   typedef enum logic [1:0] {S_ENTRY, S_OPEN, S_ERROR, S_LOCKOUT} state_t;

   localparam logic [31:0] OPEN_LD  = 32'(OPEN_CYC - 1);
   localparam logic [31:0] ERR_LD   = 32'(ERR_CYC - 1);
   localparam logic [31:0] LOCK_LD  = 32'(LOCK_CYC - 1);
   localparam logic [2:0]  MAX_F    = 3'(MAX_FAIL);

   state_t      state, state_nxt;
   logic [31:0] timer, timer_nxt;
   logic [15:0] pw, pw_nxt;
   logic [15:0] entry_nxt;
   logic [2:0]  cnt_nxt;
   logic [2:0]  fail, fail_nxt;
   logic        pw_saved_nxt;

   logic is_digit, is_clear, is_enter, full;

   assign is_digit = key_valid && (key_code <= 4'd9);
   assign is_clear = key_valid && (key_code == 4'd10);
   assign is_enter = key_valid && (key_code == 4'd11);
   assign full     = (entry_cnt == 3'd4);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_ENTRY;
         timer     <= '0;
         pw        <= DEFAULT_PW;
         entry     <= '0;
         entry_cnt <= '0;
         fail      <= '0;
         pw_saved  <= 1'b0;
      end else begin
         state     <= state_nxt;
         timer     <= timer_nxt;
         pw        <= pw_nxt;
         entry     <= entry_nxt;
         entry_cnt <= cnt_nxt;
         fail      <= fail_nxt;
         pw_saved  <= pw_saved_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      timer_nxt    = timer;
      pw_nxt       = pw;
      entry_nxt    = entry;
      cnt_nxt      = entry_cnt;
      fail_nxt     = fail;
      pw_saved_nxt = 1'b0;

      // Digit/clear editing is shared by ENTRY and OPEN; enter overrides below.
      if (is_digit && !full) begin
         entry_nxt = {entry[11:0], key_code};
         cnt_nxt   = entry_cnt + 3'd1;
      end else if (is_clear) begin
         entry_nxt = '0;
         cnt_nxt   = '0;
      end

      unique case (state)
         S_ENTRY: begin
            if (is_enter) begin
               entry_nxt = '0;
               cnt_nxt   = '0;
               if (full && (entry == pw)) begin
                  state_nxt = S_OPEN;
                  timer_nxt = OPEN_LD;
                  fail_nxt  = '0;
               end else begin
                  state_nxt = S_ERROR;
                  timer_nxt = ERR_LD;
                  fail_nxt  = (fail >= MAX_F) ? MAX_F : fail + 3'd1;
               end
            end
         end
         S_OPEN: begin
            if (timer == '0) begin
               // Expiry wins over any key strobe in the same cycle.
               state_nxt = S_ENTRY;
               entry_nxt = '0;
               cnt_nxt   = '0;
            end else begin
               timer_nxt = timer - 32'd1;
               if (is_enter) begin
                  entry_nxt = '0;
                  cnt_nxt   = '0;
                  if (full) begin
                     pw_nxt       = entry;
                     pw_saved_nxt = 1'b1;
                  end
               end
            end
         end
         S_ERROR: begin
            entry_nxt = entry;
            cnt_nxt   = entry_cnt;
            if (timer == '0) begin
               if (fail == MAX_F) begin
                  state_nxt = S_LOCKOUT;
                  timer_nxt = LOCK_LD;
               end else begin
                  state_nxt = S_ENTRY;
               end
            end else begin
               timer_nxt = timer - 32'd1;
            end
         end
         S_LOCKOUT: begin
            entry_nxt = entry;
            cnt_nxt   = entry_cnt;
            if (timer == '0) begin
               state_nxt = S_ENTRY;
               fail_nxt  = '0;
            end else begin
               timer_nxt = timer - 32'd1;
            end
         end
         default: state_nxt = S_ENTRY;
      endcase
   end

   assign open   = (state == S_OPEN);
   assign err    = (state == S_ERROR);
   assign locked = (state == S_LOCKOUT);

endmodule
